stream_mmu: RTL and testbench
=============================

// Module: stream_mmu
// PURPOSE
// - Parametrised successor of the fixed 4x64 memory management unit. Sits between the
//   aggregator (N bitstreams) and the top-level consumer.
// - Presents one W-bit stream word at a time on OUT, with a valid/ready handshake.
// - Selects the next stream round-robin or pseudo-randomly, holds each selection for a
//   programmable dwell, and shows the active channel on one-hot LEDs. D_OFF freezes the unit.
// PARAMETERS
// - W      64        width of each stream word / OUT
// - N      4         channel count, N >= 2
// - IDX_W  $clog2(N) width of CUR_IDX
// - DWELL  2         idle cycles after each handshake before the next word is offered; 0 allowed
// - SEED   16'hACE1  LFSR seed; 0 is illegal and is replaced by 16'hACE1
// PORTS
// - D_CLK      in   1        sole clock, rising edge
// - D_RST_N    in   1        synchronous, active-low reset
// - D_OFF      in   1        1 = unit off/frozen
// - MODE       in   1        0 = round-robin, 1 = pseudo-random
// - IN         in   N x W    IN[i] = aggregator stream i, sampled on capture only
// - OUT_READY  in   1        consumer accepts OUT
// - OUT        out  W        currently offered word (registered)
// - OUT_VALID  out  1        OUT holds a word not yet accepted
// - CUR_IDX    out  IDX_W    channel of OUT
// - LED        out  N        one-hot of CUR_IDX while not off; all 0 when off
// BEHAVIOUR
// - Reset:
//   - D_RST_N=0 at a clock edge forces: state S_OFF, OUT=0, OUT_VALID=0, CUR_IDX=0, LED=0,
//     dwell counter=0, LFSR=SEED.
//   - Reset overrides D_OFF and any in-flight handshake.
// - FSM states: S_OFF, S_SHOW, S_DWELL.
// - S_OFF:
//   - OUT_VALID=0, LED=0; OUT and CUR_IDX hold their values.
//   - If D_OFF=0: capture OUT<=IN[CUR_IDX] and go to S_SHOW.
//   - First word after reset is therefore valid 1 cycle after the release edge.
// - S_SHOW:
//   - OUT_VALID=1, LED=onehot(CUR_IDX).
//   - OUT, CUR_IDX and OUT_VALID stay stable until OUT_READY=1 (handshake). No timeout.
//   - On handshake with DWELL>0: go to S_DWELL with count=DWELL.
//   - On handshake with DWELL=0: select the next index, capture its word in the same edge,
//     stay in S_SHOW. Back-to-back words are then offered every cycle.
// - S_DWELL:
//   - OUT_VALID=0, LED=onehot(CUR_IDX); count decrements each cycle.
//   - At count=1: select the next index, capture OUT<=IN[next], go to S_SHOW.
//   - Handshake to next valid is DWELL+1 cycles.
// - Next-index rules:
//   - MODE=0: CUR_IDX+1, wrapping N-1 -> 0.
//   - MODE=1: r = LFSR % N; if r == CUR_IDX use (r+1) % N. Consecutive indices are never equal.
//   - MODE is sampled at selection time only; a mid-word change takes effect at the next selection.
// - LFSR:
//   - 16-bit Galois, taps 16'hB400, shift right.
//   - Advances every cycle the state is not S_OFF; holds in S_OFF.
//   - Never reaches 0.
// - D_OFF=1 in any state:
//   - Next edge enters S_OFF; an un-accepted word is not counted as a handshake.
//   - Dwell counter is cleared.
//   - On release, the same CUR_IDX is re-captured; no index advance.
//   - Simultaneous OUT_READY and D_OFF rising: D_OFF wins, no handshake.
// - Widths:
//   - All modulo arithmetic is done on IDX_W+1 bits, then truncated.
//   - Dwell counter is $clog2(DWELL+1) bits, minimum 1.
// STRUCTURE
// - doppio_pkg:
//   - mmu_state_t enum {S_OFF, S_SHOW, S_DWELL}
//   - LFSR_TAPS = 16'hB400
//   - LFSR_DEFAULT_SEED = 16'hACE1
//   - function onehot(idx, n)
// - Sub-module lfsr16 (D_CLK, D_RST_N, EN, SEED -> Q); all else in stream_mmu.
// TESTING (N=4, W=64, IN[i]=64'h1111_0000_0000_0000*(i+1) unless noted)
// - Reset: D_RST_N=0 for 2 cycles with D_OFF=0
//   -> OUT=0, OUT_VALID=0, CUR_IDX=0, LED=4'b0000.
//   -> 1 cycle after release: OUT_VALID=1, OUT=IN[0], LED=4'b0001.
// - Round-robin: MODE=0, DWELL=2, OUT_READY=1
//   -> CUR_IDX 0,1,2,3,0; a new valid word every 3 cycles.
//   -> LED 0001, 0010, 0100, 1000, 0001.
// - Backpressure: OUT_READY=0 for 5 cycles at CUR_IDX=2
//   -> OUT=IN[2], OUT_VALID=1 and CUR_IDX=2 constant for all 5 cycles.
//   -> Raise READY: one handshake, then advance to index 3.
// - Off mid-dwell: D_OFF=1 one cycle after handshake at idx 1
//   -> next edge: OUT_VALID=0, LED=0000, CUR_IDX=1.
//   -> Release: OUT_VALID=1 next cycle with CUR_IDX=1; re-capture reflects a changed IN[1].
// - Random: MODE=1, SEED=16'hACE1, DWELL=0, READY=1, 64 handshakes
//   -> Indices match a bit-exact model; no two consecutive equal; all 4 channels appear.
// - Reset dominance: D_RST_N=0 together with D_OFF=1 and OUT_READY=1 mid-S_SHOW
//   -> reset values exactly as in the Reset case, LFSR=16'hACE1.

Source files
------------

// File: rtl/stream_mmu_pkg.sv
// Shared types and constants for the stream MMU: FSM states, LFSR constants
// and the one-hot helper used to drive the channel LEDs.
package stream_mmu_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_SHOW,
    S_DWELL
  } mmu_state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Valid for channel counts up to 32; out-of-range indices give all zeros.
  function automatic logic [31:0] onehot(input int idx, input int n);
    logic [31:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < 32) v = 32'd1 << idx;
    return v;
  endfunction

endpackage

// File: rtl/stream_mmu_lfsr16.sv
// 16-bit right-shifting Galois LFSR with enable; a zero seed is swapped for
// the default so the register can never lock up at zero.
module lfsr16
  import stream_mmu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_TAPS) : (q_q >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q_q <= (seed_i == 16'h0000) ? LFSR_DEFAULT_SEED : seed_i;
    else          q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/stream_mmu.sv
// Stream MMU: offers one of N aggregator words at a time over valid/ready,
// picking channels round-robin or pseudo-randomly with a programmable dwell.
module stream_mmu
  import stream_mmu_pkg::*;
#(
  parameter int          W     = 64,
  parameter int          N     = 4,
  parameter int          IDX_W = $clog2(N),
  parameter int          DWELL = 2,
  parameter logic [15:0] SEED  = LFSR_DEFAULT_SEED
) (
  input  logic                  d_clk_i,
  input  logic                  d_rst_n_i,
  input  logic                  d_off_i,
  input  logic                  mode_i,
  input  logic [N-1:0][W-1:0]   in_i,
  input  logic                  out_ready_i,
  output logic [W-1:0]          out_o,
  output logic                  out_valid_o,
  output logic [IDX_W-1:0]      cur_idx_o,
  output logic [N-1:0]          led_o
);

  localparam int CNT_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL);
  localparam logic [IDX_W:0]   N_EXT      = (IDX_W + 1)'(N);
  localparam logic [IDX_W:0]   ONE_EXT    = (IDX_W + 1)'(1);

  mmu_state_t       state_q, state_d;
  logic [W-1:0]     out_q, out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q;

  logic [IDX_W:0]   incExt, rawExt, rndExt;
  logic [IDX_W-1:0] selIdx;

  lfsr16 u_lfsr (
    .clk_i   (d_clk_i),
    .rst_n_i (d_rst_n_i),
    .en_i    (state_q != S_OFF),
    .seed_i  (SEED),
    .q_o     (lfsr_q)
  );

  // Index arithmetic is carried one bit wider than CUR_IDX so the +1 wrap is exact.
  assign incExt = ({1'b0, idx_q} + ONE_EXT) % N_EXT;
  assign rawExt = (IDX_W + 1)'(lfsr_q % 16'(N));
  assign rndExt = (rawExt == {1'b0, idx_q}) ? (rawExt + ONE_EXT) % N_EXT : rawExt;
  assign selIdx = mode_i ? IDX_W'(rndExt) : IDX_W'(incExt);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (!d_off_i) begin
          out_d   = in_i[idx_q];
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (d_off_i) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (out_ready_i) begin
          if (DWELL > 0) begin
            state_d = S_DWELL;
            cnt_d   = DWELL_LOAD;
          end else begin
            idx_d = selIdx;
            out_d = in_i[selIdx];
          end
        end
      end
      S_DWELL: begin
        if (d_off_i) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          idx_d   = selIdx;
          out_d   = in_i[selIdx];
          cnt_d   = '0;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge d_clk_i) begin
    if (!d_rst_n_i) begin
      state_q <= S_OFF;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = (state_q == S_SHOW);
  assign cur_idx_o   = idx_q;
  assign led_o       = (state_q == S_OFF) ? '0 : N'(onehot(int'(idx_q), N));

endmodule

// File: tb/tb_stream_mmu.sv
// Self-checking bench for stream_mmu: directed table on a DWELL=2 instance and
// a reference-model random run on a DWELL=0 instance.
module tb_stream_mmu;

  localparam int W = 64;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstA_n, offA, modeA, readyA;
  logic [N-1:0][W-1:0] inA;
  logic [W-1:0]        outA;
  logic                validA;
  logic [1:0]          idxA;
  logic [N-1:0]        ledA;

  logic                rstB_n, offB, modeB, readyB;
  logic [N-1:0][W-1:0] inB;
  logic [W-1:0]        outB;
  logic                validB;
  logic [1:0]          idxB;
  logic [N-1:0]        ledB;

  stream_mmu #(.W(W), .N(N), .DWELL(2), .SEED(16'hACE1)) u_dutA (
    .d_clk_i(clk), .d_rst_n_i(rstA_n), .d_off_i(offA), .mode_i(modeA),
    .in_i(inA), .out_ready_i(readyA), .out_o(outA), .out_valid_o(validA),
    .cur_idx_o(idxA), .led_o(ledA)
  );

  stream_mmu #(.W(W), .N(N), .DWELL(0), .SEED(16'hACE1)) u_dutB (
    .d_clk_i(clk), .d_rst_n_i(rstB_n), .d_off_i(offB), .mode_i(modeB),
    .in_i(inB), .out_ready_i(readyB), .out_o(outB), .out_valid_o(validB),
    .cur_idx_o(idxB), .led_o(ledB)
  );

  typedef struct {
    logic        rstN, off, mode, ready;
    logic        valid;
    logic [1:0]  idx;
    logic [3:0]  led;
    logic [63:0] word;
  } vec_t;

  vec_t vecs[$];
  int   nTests = 0;
  int   nFail  = 0;

  // Behavioural model of the DWELL=0 instance
  logic        mOff;
  int          mIdx;
  logic [63:0] mWord;
  logic [15:0] mLfsr;

  function automatic logic [63:0] baseWord(input int i);
    return 64'h1111_0000_0000_0000 * 64'(i + 1);
  endfunction

  function automatic vec_t mk(input logic r, o, m, rd, v, input logic [1:0] ix,
                              input logic [3:0] l, input logic [63:0] w);
    vec_t x;
    x.rstN = r; x.off = o; x.mode = m; x.ready = rd;
    x.valid = v; x.idx = ix; x.led = l; x.word = w;
    return x;
  endfunction

  function automatic logic [15:0] lfsrNext(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int pickNext(input int cur, input logic mode, input logic [15:0] l);
    int r;
    if (!mode) return (cur + 1) % N;
    r = int'(l % 16'd4);
    if (r == cur) r = (r + 1) % N;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstA_n = v.rstN; offA = v.off; modeA = v.mode; readyA = v.ready;
    @(posedge clk); #1;
  endtask

  task automatic checkA(input string tag, input logic v, input logic [1:0] ix,
                        input logic [3:0] l, input logic [63:0] w);
    checkOutput({tag, ".valid"}, 64'(validA), 64'(v));
    checkOutput({tag, ".idx"},   64'(idxA),   64'(ix));
    checkOutput({tag, ".led"},   64'(ledA),   64'(l));
    checkOutput({tag, ".out"},   outA,        w);
  endtask

  task automatic modelReset();
    mOff = 1'b1; mIdx = 0; mWord = '0; mLfsr = 16'hACE1;
  endtask

  // Returns 1 when this edge completed a handshake in the model
  task automatic modelStep(input logic off, ready, mode, output logic hs);
    hs = 1'b0;
    if (mOff) begin
      if (!off) begin
        mWord = inB[mIdx];
        mOff  = 1'b0;
      end
    end else begin
      if (off) begin
        mOff = 1'b1;
      end else if (ready) begin
        mIdx  = pickNext(mIdx, mode, mLfsr);
        mWord = inB[mIdx];
        hs    = 1'b1;
      end
      mLfsr = lfsrNext(mLfsr);
    end
  endtask

  task automatic cycleB(input string tag, input logic off, ready, mode, output logic hs);
    offB = off; readyB = ready; modeB = mode;
    @(posedge clk); #1;
    modelStep(off, ready, mode, hs);
    checkOutput({tag, ".valid"}, 64'(validB), 64'(!mOff));
    checkOutput({tag, ".idx"},   64'(idxB),   64'(mIdx));
    checkOutput({tag, ".out"},   outB,        mWord);
    checkOutput({tag, ".led"},   64'(ledB),   mOff ? 64'd0 : (64'd1 << mIdx));
  endtask

  initial begin
    logic hs;
    int   hsCount, prevIdx;
    logic [3:0] seen;

    rstA_n = 1'b0; offA = 1'b0; modeA = 1'b0; readyA = 1'b0;
    rstB_n = 1'b0; offB = 1'b0; modeB = 1'b1; readyB = 1'b1;
    for (int i = 0; i < N; i++) begin
      inA[i] = baseWord(i);
      inB[i] = baseWord(i);
    end

    // rst, off, mode, ready | valid, idx, led, out
    vecs.push_back(mk(0,0,0,0, 0,0,4'b0000,64'd0));
    vecs.push_back(mk(0,0,0,0, 0,0,4'b0000,64'd0));
    vecs.push_back(mk(1,0,0,1, 1,0,4'b0001,baseWord(0)));
    vecs.push_back(mk(1,0,0,1, 0,0,4'b0001,baseWord(0)));
    vecs.push_back(mk(1,0,0,1, 0,0,4'b0001,baseWord(0)));
    vecs.push_back(mk(1,0,0,1, 1,1,4'b0010,baseWord(1)));
    vecs.push_back(mk(1,0,0,1, 0,1,4'b0010,baseWord(1)));
    vecs.push_back(mk(1,0,0,1, 0,1,4'b0010,baseWord(1)));
    vecs.push_back(mk(1,0,0,1, 1,2,4'b0100,baseWord(2)));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,0,0, 1,2,4'b0100,baseWord(2)));
    vecs.push_back(mk(1,0,0,1, 0,2,4'b0100,baseWord(2)));
    vecs.push_back(mk(1,0,0,1, 0,2,4'b0100,baseWord(2)));
    vecs.push_back(mk(1,0,0,1, 1,3,4'b1000,baseWord(3)));
    vecs.push_back(mk(1,0,0,1, 0,3,4'b1000,baseWord(3)));
    vecs.push_back(mk(1,0,0,1, 0,3,4'b1000,baseWord(3)));
    vecs.push_back(mk(1,0,0,1, 1,0,4'b0001,baseWord(0)));
    vecs.push_back(mk(1,0,0,1, 0,0,4'b0001,baseWord(0)));
    vecs.push_back(mk(1,0,0,1, 0,0,4'b0001,baseWord(0)));
    vecs.push_back(mk(1,0,0,0, 1,1,4'b0010,baseWord(1)));
    vecs.push_back(mk(1,0,0,1, 0,1,4'b0010,baseWord(1)));
    vecs.push_back(mk(1,1,0,0, 0,1,4'b0000,baseWord(1)));
    vecs.push_back(mk(1,1,0,1, 0,1,4'b0000,baseWord(1)));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkA($sformatf("vec%0d", i), vecs[i].valid, vecs[i].idx, vecs[i].led, vecs[i].word);
    end

    // Release from off re-captures the same channel with its new contents
    inA[1] = 64'hDEAD_BEEF_0123_4567;
    applyStimulus(mk(1,0,0,0, 0,0,0,0));
    checkA("offRelease", 1'b1, 2'd1, 4'b0010, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(mk(1,0,0,0, 0,0,0,0));
    checkA("offHold", 1'b1, 2'd1, 4'b0010, 64'hDEAD_BEEF_0123_4567);

    // Reset dominates D_OFF and a pending handshake
    applyStimulus(mk(0,1,0,1, 0,0,0,0));
    checkA("rstDom", 1'b0, 2'd0, 4'b0000, 64'd0);
    checkOutput("rstDom.lfsr", 64'(u_dutA.u_lfsr.q_o), 64'h0000_0000_0000_ACE1);
    applyStimulus(mk(1,0,0,0, 0,0,0,0));
    checkA("rstRelease", 1'b1, 2'd0, 4'b0001, baseWord(0));

    // DWELL=0 instance: 64 random-mode handshakes from a fresh reset
    rstB_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    modelReset();
    checkOutput("rstB.valid", 64'(validB), 64'd0);
    checkOutput("rstB.out", outB, 64'd0);
    rstB_n = 1'b1;
    cycleB("firstB", 1'b0, 1'b1, 1'b1, hs);
    hsCount = 0;
    prevIdx = int'(idxB);
    seen = 4'b0001 << idxB;
    for (int c = 0; c < 200 && hsCount < 64; c++) begin
      cycleB($sformatf("rnd%0d", hsCount), 1'b0, 1'b1, 1'b1, hs);
      if (hs) begin
        hsCount++;
        checkOutput($sformatf("rnd%0d.distinct", hsCount), 64'(int'(idxB) != prevIdx), 64'd1);
        prevIdx = int'(idxB);
        seen = seen | (4'b0001 << idxB);
      end
    end
    checkOutput("rnd.handshakes", 64'(hsCount), 64'd64);
    checkOutput("rnd.coverage", 64'(seen), 64'hF);

    // Free-running random traffic: backpressure, off pulses, mode flips, changing inputs
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) inB[$urandom_range(0, N - 1)] = {$urandom, $urandom};
      cycleB($sformatf("mix%0d", c), ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hs);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
